vic_nested_ctrl: RTL and testbench

- Parametrised vectored interrupt controller with N_SRC sources, fixed priority (index 0 highest) and a nesting stack of NEST_DEPTH saved {PC, CCodes, level} contexts.
- Sits between peripheral IRQ lines and the fetch/execute pipeline, in place of the single-source controller.
- Redirects fetch to per-source ISR vectors and restores PC/CCodes on reti.
- Supports pre-emption by strictly higher priority and tail-chaining on reti.

---
 rtl/vic_pkg.sv | 30 +++
 rtl/vic_prio_enc.sv | 19 +
 rtl/vic_nested_ctrl.sv | 131 +++++++++++++
 tb/tb_vic_nested_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vic_pkg.sv
// Shared types and helpers for the nested vectored interrupt controller.
package vic_pkg;

  localparam int CTX_PC_W  = 32;
  localparam int CTX_CC_W  = 4;
  // Wide enough to hold the idle level (N_SRC) for up to 32 sources.
  localparam int CTX_LVL_W = 6;

  // One saved context: resume PC, flags, and the level that was interrupted.
  typedef struct packed {
    logic [CTX_PC_W-1:0]  pc;
    logic [CTX_CC_W-1:0]  cc;
    logic [CTX_LVL_W-1:0] lvl;
  } ctx_t;

  // Idle level sits one below the lowest-priority source.
  function automatic logic [CTX_LVL_W-1:0] idle_lvl(input int unsigned n_src);
    return CTX_LVL_W'(n_src);
  endfunction

  // ISR vector slot address, truncated to the fetch-address width.
  function automatic logic [CTX_PC_W-1:0] vector_addr(
    input logic [CTX_PC_W-1:0]  base,
    input int unsigned          shift,
    input logic [CTX_LVL_W-1:0] id
  );
    return base + (CTX_PC_W'(id) << shift);
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Lowest-index-first priority encoder; index 0 is the highest priority.
module vic_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0]         i_req,
  output logic [$clog2(N_SRC)-1:0] o_id,
  output logic                     o_vld
);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    o_vld = |i_req;
    o_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = $clog2(N_SRC)'(i);
    end
  end

endmodule

// File: rtl/vic_nested_ctrl.sv
// Nested vectored interrupt controller: fixed priority, pre-emption,
// context stack for PC/flags, tail-chaining on reti.
module vic_nested_ctrl
  import vic_pkg::*;
#(
  parameter int              N_SRC      = 8,
  parameter int              NEST_DEPTH = 4,
  parameter int              PC_W       = CTX_PC_W,
  parameter int              CC_W       = CTX_CC_W,
  parameter logic [PC_W-1:0] ISR_BASE   = '0,
  parameter int              ISR_SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         i_irq,
  input  logic [N_SRC-1:0]         i_irq_en,
  input  logic [PC_W-1:0]          i_PC,
  input  logic [CC_W-1:0]          i_CCodes,
  input  logic                     i_NOT_FLUSH,
  input  logic                     i_reti,
  output logic                     o_IRQ_PC,
  output logic [PC_W-1:0]          o_VIC_iaddr,
  output logic [CC_W-1:0]          o_VIC_CCodes,
  output logic                     o_VIC_CCodes_ctrl,
  output logic                     o_IRQ_VIC,
  output logic [N_SRC-1:0]         o_irq_ack,
  output logic [$clog2(N_SRC)-1:0] o_active_id,
  output logic                     o_nest_full,
  output logic                     o_reti_err
);

  localparam int                   ID_W     = $clog2(N_SRC);
  localparam int                   SP_W     = $clog2(NEST_DEPTH + 1);
  localparam int                   IDX_W    = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [CTX_LVL_W-1:0] IDLE_LVL = idle_lvl(N_SRC);

  logic [N_SRC-1:0]     r_irq_q;
  logic [N_SRC-1:0]     r_pend;
  ctx_t                 r_stack [NEST_DEPTH];
  logic [SP_W-1:0]      r_sp;
  logic [CTX_LVL_W-1:0] r_cur_lvl;

  logic [N_SRC-1:0]     w_req;
  logic [ID_W-1:0]      w_cand_id;
  logic                 w_cand_vld;
  logic [CTX_LVL_W-1:0] w_cand_lvl;
  logic                 w_empty, w_full;
  logic [SP_W-1:0]      w_top_idx;
  ctx_t                 w_top;
  logic                 w_tail, w_pop, w_take;
  logic [N_SRC-1:0]     w_clr;
  logic [SP_W-1:0]      w_sp_nxt;

  // Masking applies only here; masked bits stay pending.
  assign w_req = r_pend & i_irq_en;

  vic_prio_enc #(.N_SRC(N_SRC)) u_enc (
    .i_req (w_req),
    .o_id  (w_cand_id),
    .o_vld (w_cand_vld)
  );

  assign w_cand_lvl = CTX_LVL_W'(w_cand_id);
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SP_W'(NEST_DEPTH));
  assign w_top_idx  = w_empty ? '0 : r_sp - 1'b1;
  assign w_top      = r_stack[IDX_W'(w_top_idx)];

  // reti wins over take; tail-chain compares against the level being resumed.
  assign w_tail   = i_reti & ~w_empty & w_cand_vld & (w_cand_lvl < w_top.lvl);
  assign w_pop    = i_reti & ~w_empty & ~w_tail;
  assign w_take   = ~i_reti & w_cand_vld & (w_cand_lvl < r_cur_lvl) & ~w_full & i_NOT_FLUSH;
  assign w_clr    = (w_take | w_tail) ? (N_SRC'(1) << w_cand_id) : '0;
  assign w_sp_nxt = w_take ? r_sp + 1'b1 : (w_pop ? r_sp - 1'b1 : r_sp);

  // Edge capture, pending set/clear, stack push/pop and current level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_q   <= '0;
      r_pend    <= '0;
      r_sp      <= '0;
      r_cur_lvl <= IDLE_LVL;
      for (int i = 0; i < NEST_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_irq_q <= i_irq;
      // A fresh edge in the same cycle as its clear keeps the request.
      r_pend  <= (r_pend & ~w_clr) | (i_irq & ~r_irq_q);
      r_sp    <= w_sp_nxt;
      if (w_take) begin
        r_stack[IDX_W'(r_sp)] <= '{pc: i_PC, cc: i_CCodes, lvl: r_cur_lvl};
        r_cur_lvl             <= w_cand_lvl;
      end else if (w_tail) begin
        r_cur_lvl <= w_cand_lvl;
      end else if (w_pop) begin
        r_cur_lvl <= w_top.lvl;
      end
    end
  end

  // Registered redirect, flag-restore and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_IRQ_PC          <= 1'b0;
      o_VIC_iaddr       <= '0;
      o_VIC_CCodes      <= '0;
      o_VIC_CCodes_ctrl <= 1'b0;
      o_IRQ_VIC         <= 1'b0;
      o_irq_ack         <= '0;
      o_active_id       <= '0;
      o_nest_full       <= 1'b0;
      o_reti_err        <= 1'b0;
    end else begin
      o_IRQ_PC          <= w_take | w_tail | w_pop;
      o_VIC_CCodes_ctrl <= w_pop;
      o_reti_err        <= i_reti & w_empty;
      o_irq_ack         <= w_clr;
      o_nest_full       <= (w_sp_nxt == SP_W'(NEST_DEPTH));
      if (w_take | w_tail) begin
        o_VIC_iaddr <= vector_addr(ISR_BASE, ISR_SHIFT, w_cand_lvl);
        o_IRQ_VIC   <= 1'b1;
        o_active_id <= w_cand_id;
      end else if (w_pop) begin
        o_VIC_iaddr  <= w_top.pc;
        o_VIC_CCodes <= w_top.cc;
        o_IRQ_VIC    <= (r_sp != SP_W'(1));
        o_active_id  <= (w_top.lvl == IDLE_LVL) ? '0 : ID_W'(w_top.lvl);
      end
    end
  end

endmodule

// File: tb/tb_vic_nested_ctrl.sv
// Directed bench for vic_nested_ctrl (8 sources, 2-deep stack).
module tb_vic_nested_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_irq, i_irq_en;
  logic [31:0] i_PC;
  logic [3:0]  i_CCodes;
  logic        i_NOT_FLUSH, i_reti;
  logic        o_IRQ_PC, o_VIC_CCodes_ctrl, o_IRQ_VIC, o_nest_full, o_reti_err;
  logic [31:0] o_VIC_iaddr;
  logic [3:0]  o_VIC_CCodes;
  logic [7:0]  o_irq_ack;
  logic [2:0]  o_active_id;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vic_nested_ctrl #(.N_SRC(8), .NEST_DEPTH(2), .PC_W(32), .CC_W(4),
                    .ISR_BASE(32'h0), .ISR_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .i_irq(i_irq), .i_irq_en(i_irq_en), .i_PC(i_PC),
    .i_CCodes(i_CCodes), .i_NOT_FLUSH(i_NOT_FLUSH), .i_reti(i_reti),
    .o_IRQ_PC(o_IRQ_PC), .o_VIC_iaddr(o_VIC_iaddr), .o_VIC_CCodes(o_VIC_CCodes),
    .o_VIC_CCodes_ctrl(o_VIC_CCodes_ctrl), .o_IRQ_VIC(o_IRQ_VIC),
    .o_irq_ack(o_irq_ack), .o_active_id(o_active_id),
    .o_nest_full(o_nest_full), .o_reti_err(o_reti_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reti_pulse();
    i_reti = 1'b1;
    @(negedge clk);
    i_reti = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_irq = '0; i_irq_en = 8'hFF; i_PC = '0; i_CCodes = '0;
    i_NOT_FLUSH = 1'b1; i_reti = 1'b0;
    nx(3);
    chk("rst_irq_pc", o_IRQ_PC, 0);
    chk("rst_iaddr", o_VIC_iaddr, 0);
    chk("rst_vic", o_IRQ_VIC, 0);
    chk("rst_ack", o_irq_ack, 0);
    chk("rst_id", o_active_id, 0);
    chk("rst_full", o_nest_full, 0);
    chk("rst_err", o_reti_err, 0);
    chk("rst_ccctrl", o_VIC_CCodes_ctrl, 0);
    rst = 1'b1;
    nx(1);

    // single IRQ and return
    i_PC = 32'h100; i_CCodes = 4'hA; i_irq[3] = 1'b1;
    nx(1); chk("t1_not_yet", o_IRQ_PC, 0);
    nx(1);
    chk("t1_irq_pc", o_IRQ_PC, 1);
    chk("t1_iaddr", o_VIC_iaddr, 32'h30);
    chk("t1_ack", o_irq_ack, 8'h08);
    chk("t1_vic", o_IRQ_VIC, 1);
    chk("t1_id", o_active_id, 3);
    i_PC = 32'h130; i_CCodes = 4'h0;
    nx(1);
    chk("t1_pulse_off", o_IRQ_PC, 0);
    chk("t1_ack_off", o_irq_ack, 0);
    reti_pulse();
    chk("t1_ret_pc", o_IRQ_PC, 1);
    chk("t1_ret_iaddr", o_VIC_iaddr, 32'h100);
    chk("t1_ret_cc", o_VIC_CCodes, 4'hA);
    chk("t1_ret_ccctrl", o_VIC_CCodes_ctrl, 1);
    chk("t1_ret_vic", o_IRQ_VIC, 0);
    nx(1);
    chk("t1_ccctrl_off", o_VIC_CCodes_ctrl, 0);
    i_irq = '0; nx(1);

    // pre-emption
    i_PC = 32'h200; i_CCodes = 4'h3; i_irq[5] = 1'b1;
    nx(2);
    chk("t2_iaddr5", o_VIC_iaddr, 32'h50);
    chk("t2_full0", o_nest_full, 0);
    i_PC = 32'h208; i_CCodes = 4'h5; i_irq[1] = 1'b1;
    nx(2);
    chk("t2_iaddr1", o_VIC_iaddr, 32'h10);
    chk("t2_id1", o_active_id, 1);
    chk("t2_full1", o_nest_full, 1);
    i_PC = 32'h10;
    reti_pulse();
    chk("t2_ret1_iaddr", o_VIC_iaddr, 32'h208);
    chk("t2_ret1_cc", o_VIC_CCodes, 4'h5);
    chk("t2_ret1_id", o_active_id, 5);
    chk("t2_ret1_vic", o_IRQ_VIC, 1);
    chk("t2_ret1_full", o_nest_full, 0);
    reti_pulse();
    chk("t2_ret2_iaddr", o_VIC_iaddr, 32'h200);
    chk("t2_ret2_cc", o_VIC_CCodes, 4'h3);
    chk("t2_ret2_vic", o_IRQ_VIC, 0);
    i_irq = '0; nx(1);

    // lower priority waits, then tail-chains
    i_PC = 32'h300; i_CCodes = 4'h1; i_irq[2] = 1'b1;
    nx(2);
    chk("t3_iaddr2", o_VIC_iaddr, 32'h20);
    i_PC = 32'h320; i_irq[6] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nx(1); chk("t3_no_preempt", o_IRQ_PC, 0);
    end
    chk("t3_id2", o_active_id, 2);
    reti_pulse();
    chk("t3_tail_pc", o_IRQ_PC, 1);
    chk("t3_tail_iaddr", o_VIC_iaddr, 32'h60);
    chk("t3_tail_ccctrl", o_VIC_CCodes_ctrl, 0);
    chk("t3_tail_id", o_active_id, 6);
    chk("t3_tail_ack", o_irq_ack, 8'h40);
    chk("t3_tail_vic", o_IRQ_VIC, 1);
    reti_pulse();
    chk("t3_ret_iaddr", o_VIC_iaddr, 32'h300);
    chk("t3_ret_cc", o_VIC_CCodes, 4'h1);
    chk("t3_ret_ccctrl", o_VIC_CCodes_ctrl, 1);
    chk("t3_ret_vic", o_IRQ_VIC, 0);
    i_irq = '0; nx(1);

    // bubble: no take until the execute stage is valid
    i_NOT_FLUSH = 1'b0; i_PC = 32'h400; i_CCodes = 4'h0; i_irq[4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nx(1); chk("t4_bubble_hold", o_IRQ_PC, 0);
    end
    i_NOT_FLUSH = 1'b1; i_PC = 32'h444; i_CCodes = 4'h7;
    nx(1);
    chk("t4_take_pc", o_IRQ_PC, 1);
    chk("t4_iaddr", o_VIC_iaddr, 32'h40);
    reti_pulse();
    chk("t4_ret_iaddr", o_VIC_iaddr, 32'h444);
    chk("t4_ret_cc", o_VIC_CCodes, 4'h7);
    i_irq = '0; nx(1);

    // stack full, tail-chain out of it, then empty-stack reti
    i_PC = 32'h500; i_CCodes = 4'h2; i_irq[7] = 1'b1;
    nx(2);
    chk("t5_iaddr7", o_VIC_iaddr, 32'h70);
    i_PC = 32'h570; i_CCodes = 4'h4; i_irq[4] = 1'b1;
    nx(2);
    chk("t5_iaddr4", o_VIC_iaddr, 32'h40);
    chk("t5_full", o_nest_full, 1);
    i_PC = 32'h540; i_irq[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nx(1); chk("t5_full_wait", o_IRQ_PC, 0);
    end
    chk("t5_full_hold", o_nest_full, 1);
    i_NOT_FLUSH = 1'b0;
    reti_pulse();
    chk("t5_tail_pc", o_IRQ_PC, 1);
    chk("t5_tail_iaddr", o_VIC_iaddr, 32'h0);
    chk("t5_tail_ack", o_irq_ack, 8'h01);
    chk("t5_tail_ccctrl", o_VIC_CCodes_ctrl, 0);
    chk("t5_tail_id", o_active_id, 0);
    chk("t5_tail_full", o_nest_full, 1);
    i_NOT_FLUSH = 1'b1;
    reti_pulse();
    chk("t5_ret1_iaddr", o_VIC_iaddr, 32'h570);
    chk("t5_ret1_cc", o_VIC_CCodes, 4'h4);
    chk("t5_ret1_id", o_active_id, 7);
    chk("t5_ret1_full", o_nest_full, 0);
    reti_pulse();
    chk("t5_ret2_iaddr", o_VIC_iaddr, 32'h500);
    chk("t5_ret2_cc", o_VIC_CCodes, 4'h2);
    chk("t5_ret2_vic", o_IRQ_VIC, 0);
    reti_pulse();
    chk("t5_err", o_reti_err, 1);
    chk("t5_err_no_redirect", o_IRQ_PC, 0);
    nx(1);
    chk("t5_err_off", o_reti_err, 0);
    i_irq = '0; nx(1);

    // mask holds the request; async reset mid-ISR clears everything
    i_irq_en = 8'hFB; i_PC = 32'h600; i_CCodes = 4'h6; i_irq[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nx(1); chk("t6_masked", o_IRQ_PC, 0);
    end
    i_irq_en = 8'hFF;
    nx(1);
    chk("t6_take_pc", o_IRQ_PC, 1);
    chk("t6_iaddr", o_VIC_iaddr, 32'h20);
    chk("t6_ack", o_irq_ack, 8'h04);
    nx(1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_vic", o_IRQ_VIC, 0);
    chk("t6_rst_iaddr", o_VIC_iaddr, 0);
    chk("t6_rst_id", o_active_id, 0);
    chk("t6_rst_cc", o_VIC_CCodes, 0);
    i_irq = '0;
    nx(1);
    rst = 1'b1;
    nx(1);
    reti_pulse();
    chk("t6_post_rst_err", o_reti_err, 1);
    chk("t6_post_rst_pc", o_IRQ_PC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
